// File: rtl/knock_key_seq.sv
// Knock-sequence key engine: a programmed address sequence of qualified reads unlocks an LFSR keystream.
// Latency: state/idx/LFSR update on the strobe edge and are visible next cycle; dout/dout_oe are combinational.
// No backpressure: every qualified strobe is one step. Optional brute-force lockout under KNOCK_KEY_LOCKOUT_EN.
module knock_key_seq #(
  parameter int                      ADDR_W      = 4,
  parameter int                      STEPS       = 4,
  parameter logic [STEPS*ADDR_W-1:0] KEY         = 16'hC3A5,
  parameter logic [ADDR_W-1:0]       RELOCK_ADDR = 4'hF,
  parameter int                      STATE_W     = 6,
  parameter logic [STATE_W-1:0]      TAPS        = 6'h30,
  parameter logic [STATE_W-1:0]      SEED        = 6'h01,
  parameter logic [STATE_W-1:0]      OUT_MASK    = 6'h01,
  parameter int                      FAIL_LIMIT  = 8,
  localparam int                     IDX_W       = (STEPS > 1) ? $clog2(STEPS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic              rd,
  input  logic              acc_stb,
  input  logic [ADDR_W-1:0] addr,
  output logic              dout,
  output logic              dout_oe,
  output logic              unlocked,
  output logic              lockout,
  output logic [IDX_W-1:0]  step_idx
);

  if (STEPS < 2 || SEED == '0 || FAIL_LIMIT < 1) begin : g_param_chk
    $error("knock_key_seq: STEPS must be >= 2, SEED nonzero, FAIL_LIMIT >= 1");
  end

  typedef enum logic [1:0] {S_LOCKED, S_UNLOCKED, S_LOCKOUT} state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic [STATE_W-1:0] r_lfsr, w_lfsr_nxt;
  logic               w_acc;
  logic [ADDR_W-1:0]  w_key_cur;
  logic               w_hit_cur, w_hit_first, w_last_step;

  assign w_acc       = acc_stb & sel & rd;
  assign w_key_cur   = KEY[int'(r_idx)*ADDR_W +: ADDR_W];
  assign w_hit_cur   = (addr == w_key_cur);
  assign w_hit_first = (addr == KEY[ADDR_W-1:0]);
  assign w_last_step = (r_idx == IDX_W'(STEPS-1));

`ifdef KNOCK_KEY_LOCKOUT_EN
  localparam int FAIL_W = $clog2(FAIL_LIMIT+1);
  logic [FAIL_W-1:0] r_fail_cnt, w_fail_nxt;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_lfsr_nxt  = r_lfsr;
`ifdef KNOCK_KEY_LOCKOUT_EN
    w_fail_nxt  = r_fail_cnt;
`endif
    case (r_state)
      S_LOCKED: begin
        w_lfsr_nxt = SEED;
        if (w_acc) begin
          if (w_hit_cur && w_last_step) begin
            w_state_nxt = S_UNLOCKED;
            w_idx_nxt   = '0;
`ifdef KNOCK_KEY_LOCKOUT_EN
            w_fail_nxt  = '0;
`endif
          end else if (w_hit_cur) begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end else begin
            // A mismatching first-key address still counts as the start of a new attempt
            w_idx_nxt = w_hit_first ? IDX_W'(1) : '0;
`ifdef KNOCK_KEY_LOCKOUT_EN
            if (r_idx != '0) begin
              if (r_fail_cnt != FAIL_W'(FAIL_LIMIT))
                w_fail_nxt = r_fail_cnt + FAIL_W'(1);
              if (w_fail_nxt == FAIL_W'(FAIL_LIMIT)) begin
                w_state_nxt = S_LOCKOUT;
                w_idx_nxt   = '0;
              end
            end
`endif
          end
        end
      end
      S_UNLOCKED: begin
        if (w_acc) begin
          if (addr == RELOCK_ADDR) begin
            w_state_nxt = S_LOCKED;
            w_idx_nxt   = '0;
            w_lfsr_nxt  = SEED;
          end else begin
            w_lfsr_nxt = {r_lfsr[STATE_W-2:0], ^(r_lfsr & TAPS)};
          end
        end
      end
      S_LOCKOUT: ;
      default: begin
        w_state_nxt = S_LOCKED;
        w_idx_nxt   = '0;
        w_lfsr_nxt  = SEED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_LOCKED;
      r_idx      <= '0;
      r_lfsr     <= SEED;
`ifdef KNOCK_KEY_LOCKOUT_EN
      r_fail_cnt <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_lfsr     <= w_lfsr_nxt;
`ifdef KNOCK_KEY_LOCKOUT_EN
      r_fail_cnt <= w_fail_nxt;
`endif
    end
  end

  assign unlocked = (r_state == S_UNLOCKED);
`ifdef KNOCK_KEY_LOCKOUT_EN
  assign lockout  = (r_state == S_LOCKOUT);
`else
  assign lockout  = 1'b0;
`endif
  assign dout     = lockout ? 1'b0 : ^(r_lfsr & OUT_MASK);
  assign dout_oe  = sel & rd;
  assign step_idx = r_idx;

endmodule

// File: tb/tb_knock_key_seq.sv
// Directed bench for knock_key_seq with default parameters (key 5,A,3,C; relock F; LFSR seed 01, taps 30).
module tb_knock_key_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic       rd = 1'b0;
  logic       acc_stb = 1'b0;
  logic [3:0] addr = 4'h0;
  logic       dout, dout_oe, unlocked, lockout;
  logic [1:0] step_idx;

  int n_cmp = 0;
  int n_bad = 0;

  knock_key_seq dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .rd(rd), .acc_stb(acc_stb), .addr(addr),
    .dout(dout), .dout_oe(dout_oe), .unlocked(unlocked), .lockout(lockout), .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  // One strobe cycle; d/oe are sampled while the strobe is applied, before the update edge.
  task automatic acc(input logic [3:0] a, input logic s, input logic r,
                     output logic d, output logic oe);
    @(negedge clk);
    sel = s; rd = r; acc_stb = 1'b1; addr = a;
    #1;
    d  = dout;
    oe = dout_oe;
    @(posedge clk);
    #1;
    acc_stb = 1'b0; sel = 1'b0; rd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic knock();
    logic d, oe;
    logic [3:0] seq [4] = '{4'h5, 4'hA, 4'h3, 4'hC};
    foreach (seq[i]) acc(seq[i], 1'b1, 1'b1, d, oe);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; sel = 1'b1; rd = 1'b1;
    #1;
    n_cmp++; if (unlocked !== 1'b0) begin n_bad++; $display("FAIL reset_unlocked got %b want 0", unlocked); end
    n_cmp++; if (lockout !== 1'b0) begin n_bad++; $display("FAIL reset_lockout got %b want 0", lockout); end
    n_cmp++; if (step_idx !== 2'd0) begin n_bad++; $display("FAIL reset_idx got %0d want 0", step_idx); end
    n_cmp++; if (dout !== 1'b1) begin n_bad++; $display("FAIL reset_dout got %b want 1", dout); end
    n_cmp++; if (dout_oe !== 1'b1) begin n_bad++; $display("FAIL reset_oe got %b want 1", dout_oe); end
    sel = 1'b0; rd = 1'b0;
    #1;
    n_cmp++; if (dout_oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe_idle got %b want 0", dout_oe); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unlock_keystream();
    logic d, oe;
    logic [3:0] seq [4]     = '{4'h5, 4'hA, 4'h3, 4'hC};
    logic [1:0] exp_idx [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic       exp_ul [4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       exp_ks [7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    foreach (seq[i]) begin
      acc(seq[i], 1'b1, 1'b1, d, oe);
      n_cmp++; if (step_idx !== exp_idx[i]) begin n_bad++; $display("FAIL unlock_idx[%0d] got %0d want %0d", i, step_idx, exp_idx[i]); end
      n_cmp++; if (unlocked !== exp_ul[i]) begin n_bad++; $display("FAIL unlock_flag[%0d] got %b want %b", i, unlocked, exp_ul[i]); end
    end
    foreach (exp_ks[i]) begin
      acc(4'h7, 1'b1, 1'b1, d, oe);
      n_cmp++; if (d !== exp_ks[i]) begin n_bad++; $display("FAIL keystream[%0d] got %b want %b", i, d, exp_ks[i]); end
    end
    n_cmp++; if (unlocked !== 1'b1) begin n_bad++; $display("FAIL keystream_stays_unlocked got %b want 1", unlocked); end
  endtask

  task automatic test_rewind();
    logic d, oe;
    logic [3:0] seq [6]     = '{4'h5, 4'hA, 4'h5, 4'hA, 4'h3, 4'hC};
    logic [1:0] exp_idx [6] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd3, 2'd0};
    logic       exp_ul [6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    foreach (seq[i]) begin
      acc(seq[i], 1'b1, 1'b1, d, oe);
      n_cmp++; if (step_idx !== exp_idx[i]) begin n_bad++; $display("FAIL rewind_idx[%0d] got %0d want %0d", i, step_idx, exp_idx[i]); end
      n_cmp++; if (unlocked !== exp_ul[i]) begin n_bad++; $display("FAIL rewind_flag[%0d] got %b want %b", i, unlocked, exp_ul[i]); end
    end
  endtask

  task automatic test_ignored();
    logic d, oe;
    logic [3:0] seq [4] = '{4'h5, 4'hA, 4'h3, 4'hC};
    do_reset();
    foreach (seq[i]) begin
      acc(seq[i], 1'b1, 1'b0, d, oe);
      n_cmp++; if (oe !== 1'b0) begin n_bad++; $display("FAIL write_oe[%0d] got %b want 0", i, oe); end
      n_cmp++; if (step_idx !== 2'd0) begin n_bad++; $display("FAIL write_idx[%0d] got %0d want 0", i, step_idx); end
    end
    foreach (seq[i]) begin
      acc(seq[i], 1'b0, 1'b1, d, oe);
      n_cmp++; if (oe !== 1'b0) begin n_bad++; $display("FAIL nosel_oe[%0d] got %b want 0", i, oe); end
      n_cmp++; if (step_idx !== 2'd0) begin n_bad++; $display("FAIL nosel_idx[%0d] got %0d want 0", i, step_idx); end
    end
    n_cmp++; if (unlocked !== 1'b0) begin n_bad++; $display("FAIL ignored_unlocked got %b want 0", unlocked); end
    acc(4'h5, 1'b1, 1'b1, d, oe);
    n_cmp++; if (oe !== 1'b1) begin n_bad++; $display("FAIL read_oe got %b want 1", oe); end
  endtask

  task automatic test_relock();
    logic d, oe;
    do_reset();
    // F is an ordinary mismatch while locked
    acc(4'h5, 1'b1, 1'b1, d, oe);
    acc(4'hF, 1'b1, 1'b1, d, oe);
    n_cmp++; if (step_idx !== 2'd0) begin n_bad++; $display("FAIL locked_f_idx got %0d want 0", step_idx); end
    n_cmp++; if (unlocked !== 1'b0) begin n_bad++; $display("FAIL locked_f_flag got %b want 0", unlocked); end
    knock();
    acc(4'h1, 1'b1, 1'b1, d, oe);
    acc(4'h1, 1'b1, 1'b1, d, oe);
    acc(4'h1, 1'b1, 1'b1, d, oe);
    acc(4'hF, 1'b1, 1'b1, d, oe);
    n_cmp++; if (d !== 1'b0) begin n_bad++; $display("FAIL relock_read_dout got %b want 0", d); end
    n_cmp++; if (unlocked !== 1'b0) begin n_bad++; $display("FAIL relock_flag got %b want 0", unlocked); end
    n_cmp++; if (dout !== 1'b1) begin n_bad++; $display("FAIL relock_seed_dout got %b want 1", dout); end
    knock();
    acc(4'h1, 1'b1, 1'b1, d, oe);
    n_cmp++; if (d !== 1'b1) begin n_bad++; $display("FAIL reunlock_ks0 got %b want 1", d); end
    acc(4'h1, 1'b1, 1'b1, d, oe);
    n_cmp++; if (d !== 1'b0) begin n_bad++; $display("FAIL reunlock_ks1 got %b want 0", d); end
  endtask

  task automatic test_async_reset();
    logic d, oe;
    do_reset();
    acc(4'h5, 1'b1, 1'b1, d, oe);
    acc(4'hA, 1'b1, 1'b1, d, oe);
    acc(4'h3, 1'b1, 1'b1, d, oe);
    n_cmp++; if (step_idx !== 2'd3) begin n_bad++; $display("FAIL pre_reset_idx got %0d want 3", step_idx); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (step_idx !== 2'd0) begin n_bad++; $display("FAIL arst_idx got %0d want 0", step_idx); end
    @(negedge clk);
    rst_n = 1'b1;
    knock();
    acc(4'h1, 1'b1, 1'b1, d, oe);
    acc(4'h1, 1'b1, 1'b1, d, oe);
    n_cmp++; if (dout !== 1'b0) begin n_bad++; $display("FAIL pre_reset_dout got %b want 0", dout); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (unlocked !== 1'b0) begin n_bad++; $display("FAIL arst_unlocked got %b want 0", unlocked); end
    n_cmp++; if (dout !== 1'b1) begin n_bad++; $display("FAIL arst_dout got %b want 1", dout); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lockout();
    logic d, oe;
    do_reset();
    for (int r = 0; r < 7; r++) begin
      acc(4'h5, 1'b1, 1'b1, d, oe);
      acc(4'hB, 1'b1, 1'b1, d, oe);
    end
    n_cmp++; if (lockout !== 1'b0) begin n_bad++; $display("FAIL lockout_after7 got %b want 0", lockout); end
    acc(4'h5, 1'b1, 1'b1, d, oe);
    acc(4'hB, 1'b1, 1'b1, d, oe);
    n_cmp++; if (step_idx !== 2'd0) begin n_bad++; $display("FAIL lockout_idx got %0d want 0", step_idx); end
`ifdef KNOCK_KEY_LOCKOUT_EN
    n_cmp++; if (lockout !== 1'b1) begin n_bad++; $display("FAIL lockout_after8 got %b want 1", lockout); end
    acc(4'h5, 1'b1, 1'b1, d, oe);
    n_cmp++; if (d !== 1'b0) begin n_bad++; $display("FAIL lockout_dout got %b want 0", d); end
    acc(4'hA, 1'b1, 1'b1, d, oe);
    acc(4'h3, 1'b1, 1'b1, d, oe);
    acc(4'hC, 1'b1, 1'b1, d, oe);
    n_cmp++; if (unlocked !== 1'b0) begin n_bad++; $display("FAIL lockout_no_unlock got %b want 0", unlocked); end
    do_reset();
    n_cmp++; if (lockout !== 1'b0) begin n_bad++; $display("FAIL lockout_reset got %b want 0", lockout); end
`else
    n_cmp++; if (lockout !== 1'b0) begin n_bad++; $display("FAIL lockout_tied got %b want 0", lockout); end
    knock();
    n_cmp++; if (unlocked !== 1'b1) begin n_bad++; $display("FAIL no_lockout_unlock got %b want 1", unlocked); end
`endif
  endtask

  initial begin
    test_reset();
    test_unlock_keystream();
    test_rewind();
    test_ignored();
    test_relock();
    test_async_reset();
    test_lockout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
